// File: rtl/ls161_div_ctrl.sv
// ls161_div_ctrl
// Control stage around one LS161a 4-bit counter. It programs the counter as a
// divide-by-N tick generator (N = DIV_M1+1, 1..16). Runs can be continuous or
// one-shot, and can be paused or stopped. The counter is loaded with ~DIV_M1
// and then counts up to 15. At 15 its RCO marks the terminal count. On that
// cycle the counter is reloaded rather than allowed to wrap, so every period
// is exactly N unpaused cycles long.

module ls161_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR_n,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             ONESHOT,
  input  logic [3:0]       DIV_M1,
  input  logic [3:0]       CNT_Q,
  input  logic             CNT_RCO,
  output logic [3:0]       CNT_D,
  output logic             CNT_LOAD_n,
  output logic             CNT_ENP,
  output logic             CNT_ENT,
  output logic             TICK,
  output logic             DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] TICK_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       div_m1_lat_r;
  logic             oneshot_lat_r;
  logic             done_r;
  logic [CNT_W-1:0] tick_cnt_r;

  logic             load_n_s;
  logic             enp_s;
  logic             ent_s;
  logic             term_s;
  logic             start_acc_s;

  // Q is only of interest to observers; the control path works from RCO alone.
  logic             cnt_q_unused_s;
  assign cnt_q_unused_s = ^CNT_Q;

  // Next-state decode and counter control; terminal count is qualified by PAUSE and STOP.
  always_comb begin
    state_nxt_s = state_r;
    load_n_s    = 1'b1;
    enp_s       = 1'b0;
    ent_s       = 1'b0;
    term_s      = 1'b0;
    start_acc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          start_acc_s = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_n_s = 1'b0;
        if (STOP) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        ent_s    = 1'b1;
        enp_s    = ~PAUSE;
        term_s   = CNT_RCO & ~PAUSE & ~STOP;
        load_n_s = ~term_s;
        if (STOP) begin
          state_nxt_s = ST_IDLE;
        end else if (term_s && oneshot_lat_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run configuration is captured only when a START is accepted from IDLE.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      div_m1_lat_r  <= 4'd0;
      oneshot_lat_r <= 1'b0;
    end else if (start_acc_s) begin
      div_m1_lat_r  <= DIV_M1;
      oneshot_lat_r <= ONESHOT;
    end
  end

  // Tick tally: cleared by an accepted START, bumped on every terminal count.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else if (start_acc_s) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else if (term_s) begin
      tick_cnt_r <= tick_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // DONE is high for the cycle after the last tick of a one-shot run.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= term_s & oneshot_lat_r;
    end
  end

  assign CNT_D      = ~div_m1_lat_r;
  assign CNT_LOAD_n = load_n_s;
  assign CNT_ENP    = enp_s;
  assign CNT_ENT    = ent_s;
  assign TICK       = term_s;
  assign DONE       = done_r;
  assign BUSY       = (state_r != ST_IDLE);
  assign TICK_CNT   = tick_cnt_r;

endmodule
